generation_controller: RTL and testbench
========================================

GENERATION_CONTROLLER -- requirements
Module: generation_controller

Interface
REQ-001 The block SHALL have parameter BASE_DIV, default 1024, the prescaler divide ratio; legal range is 2..65535.
REQ-002 The block SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port run_sw, input, 1 bit: 1 = run mode, 0 = edit mode; level, pre-synchronised.
REQ-005 The block SHALL have port pause_sw, input, 1 bit: 1 = ignore generation ticks, advance only on step_req.
REQ-006 The block SHALL have port step_req, input, 1 bit: single-cycle step request pulse, pre-synchronised.
REQ-007 The block SHALL have port speed, input, 3 bits: generation interval = (8 - speed) base ticks.
REQ-008 The block SHALL have port next_valid, input, 1 bit: cell array has next generation ready.
REQ-009 The block SHALL have port board_changed, input, 1 bit: next generation differs from current; valid only when next_valid=1.
REQ-010 The block SHALL have port board_empty, input, 1 bit: next generation has zero live cells; valid only when next_valid=1.
REQ-011 The block SHALL have port load_edit, output, 1 bit: one-cycle pulse to copy the edit pattern into the cell array.
REQ-012 The block SHALL have port compute, output, 1 bit: one-cycle pulse to start next-generation evaluation.
REQ-013 The block SHALL have port commit, output, 1 bit: one-cycle pulse to latch the next generation as current.
REQ-014 The block SHALL have port display_sel, output, 1 bit: 0 = display edit buffer, 1 = display live array.
REQ-015 The block SHALL have port halted, output, 1 bit: 1 while in HALT.
REQ-016 The block SHALL have port gen_count, output, 16 bits: generations committed since the last LOAD.
REQ-017 The block SHALL have port state, output, 3 bits: current FSM state code.

Function
REQ-018 The FSM SHALL use these state codes: EDIT=0, LOAD=1, IDLE=2, COMPUTE=3, WAIT=4, COMMIT=5, HALT=6; code 7 SHALL return to EDIT on the next cycle.
REQ-019 A prescaler SHALL count 0..BASE_DIV-1 and assert base_tick for one cycle on wrap.
REQ-020 An interval counter SHALL count base_ticks and assert gen_tick for one cycle when it reaches (8 - speed), then clear; speed is sampled at each compare.
REQ-021 The prescaler and interval counter SHALL both clear in LOAD and EDIT.
REQ-022 In EDIT, display_sel SHALL be 0; when run_sw=1 the FSM SHALL go to LOAD.
REQ-023 In LOAD, load_edit SHALL be 1 for exactly one cycle and gen_count SHALL clear to 0; the FSM SHALL go to IDLE next.
REQ-024 In IDLE, LOAD, COMPUTE, WAIT, COMMIT and HALT, display_sel SHALL be 1.
REQ-025 In IDLE: if run_sw=0, go to EDIT; else if (gen_tick and pause_sw=0) or step_req, go to COMPUTE; a simultaneous gen_tick and step_req SHALL produce exactly one generation.
REQ-026 In COMPUTE, compute SHALL be 1 for exactly one cycle; the FSM SHALL go to WAIT next.
REQ-027 In WAIT, the FSM SHALL stay until next_valid=1; it SHALL then register board_changed and board_empty and go to COMMIT.
REQ-028 In WAIT, if run_sw=0, the FSM SHALL go to EDIT with no commit pulse; this abort SHALL take priority over next_valid.
REQ-029 In COMMIT, commit SHALL be 1 for exactly one cycle and gen_count SHALL increment, saturating at 16'hFFFF.
REQ-030 After COMMIT, the FSM SHALL go to HALT if the registered board_empty=1 or board_changed=0; otherwise to IDLE.
REQ-031 In HALT, halted SHALL be 1; step_req and gen_tick SHALL be ignored; run_sw=0 SHALL go to EDIT.
REQ-032 gen_tick and step_req arriving outside IDLE SHALL be dropped, not queued.
REQ-033 load_edit, compute and commit SHALL be mutually exclusive and registered outputs.

Reset
REQ-034 While Reset=0 at a rising Clock edge, the block SHALL enter EDIT with all of the following cleared: state=0, load_edit=0, compute=0, commit=0, display_sel=0, halted=0, gen_count=0, prescaler=0, interval counter=0.
REQ-035 Reset SHALL override every transition, including mid-WAIT; no pulse output SHALL be asserted in the cycle after reset is released.

Verification
REQ-036 Scenario 1: BASE_DIV=4, speed=7, run_sw 0->1, next_valid returned 2 cycles after compute, board_changed=1 -> load_edit pulse, then first compute pulse 4 cycles after entering IDLE, commit, gen_count=1, FSM returns to IDLE.
REQ-037 Scenario 2: speed=0, pause_sw=0 -> compute pulses spaced 8*BASE_DIV + handshake cycles apart; 3 generations -> gen_count=3.
REQ-038 Scenario 3: pause_sw=1, two step_req pulses in IDLE, one step_req during WAIT -> exactly two commits, gen_count=2.
REQ-039 Scenario 4: next_valid with board_changed=0 -> commit pulse, then HALT, halted=1, further steps ignored; run_sw=0 -> EDIT, display_sel=0.
REQ-040 Scenario 5: run_sw=0 while in WAIT -> EDIT the next cycle, commit never asserted, gen_count unchanged.
REQ-041 Scenario 6: Reset=0 asserted in WAIT with gen_count=5 -> next cycle state=0, gen_count=0, all pulse outputs 0; gen_count forced to 16'hFFFF then one commit -> gen_count stays 16'hFFFF.

Source files
------------

// File: rtl/generation_controller.sv
// Life-board generation sequencer: paces generations from a prescaled tick or manual steps
// and issues load/compute/commit pulses to the cell array.
module generation_controller #(
    parameter int unsigned BASE_DIV = 1024
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        run_sw,
    input  logic        pause_sw,
    input  logic        step_req,
    input  logic [2:0]  speed,
    input  logic        next_valid,
    input  logic        board_changed,
    input  logic        board_empty,
    output logic        load_edit,
    output logic        compute,
    output logic        commit,
    output logic        display_sel,
    output logic        halted,
    output logic [15:0] gen_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StEdit    = 3'd0,
        StLoad    = 3'd1,
        StIdle    = 3'd2,
        StCompute = 3'd3,
        StWait    = 3'd4,
        StCommit  = 3'd5,
        StHalt    = 3'd6,
        StBad     = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [3:0]  interval_q, interval_d;
    logic [15:0] gen_count_q, gen_count_d;
    logic        changed_q, changed_d;
    logic        empty_q, empty_d;
    logic        load_edit_q, load_edit_d;
    logic        compute_q, compute_d;
    logic        commit_q, commit_d;
    logic        base_tick, gen_tick;
    logic [3:0]  interval_len;

    assign interval_len = 4'd8 - {1'b0, speed};
    assign base_tick    = (presc_q == 16'(BASE_DIV - 1));
    assign gen_tick     = base_tick && ((interval_q + 4'd1) >= interval_len);

    // Timebase only advances while waiting in IDLE, so the interval restarts after each
    // handshake instead of overlapping it.
    always_comb begin
        presc_d    = presc_q;
        interval_d = interval_q;
        if (state_q == StEdit || state_q == StLoad) begin
            presc_d    = '0;
            interval_d = '0;
        end else if (state_q == StIdle) begin
            presc_d = base_tick ? '0 : presc_q + 16'd1;
            if (gen_tick) begin
                interval_d = '0;
            end else if (base_tick) begin
                interval_d = interval_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        changed_d   = changed_q;
        empty_d     = empty_q;
        gen_count_d = gen_count_q;
        case (state_q)
            StEdit: begin
                if (run_sw) state_d = StLoad;
            end
            StLoad: begin
                gen_count_d = '0;
                state_d     = StIdle;
            end
            StIdle: begin
                if (!run_sw) begin
                    state_d = StEdit;
                end else if ((gen_tick && !pause_sw) || step_req) begin
                    state_d = StCompute;
                end
            end
            StCompute: state_d = StWait;
            StWait: begin
                if (!run_sw) begin
                    state_d = StEdit;
                end else if (next_valid) begin
                    changed_d = board_changed;
                    empty_d   = board_empty;
                    state_d   = StCommit;
                end
            end
            StCommit: begin
                if (gen_count_q != 16'hFFFF) gen_count_d = gen_count_q + 16'd1;
                state_d = (empty_q || !changed_q) ? StHalt : StIdle;
            end
            StHalt: begin
                if (!run_sw) state_d = StEdit;
            end
            default: state_d = StEdit;
        endcase
    end

    always_comb begin
        load_edit_d = (state_d == StLoad);
        compute_d   = (state_d == StCompute);
        commit_d    = (state_d == StCommit);
        halted      = (state_q == StHalt);
        display_sel = 1'b0;
        case (state_q)
            StLoad, StIdle, StCompute, StWait, StCommit, StHalt: display_sel = 1'b1;
            default: display_sel = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= StEdit;
            presc_q     <= '0;
            interval_q  <= '0;
            gen_count_q <= '0;
            changed_q   <= 1'b0;
            empty_q     <= 1'b0;
            load_edit_q <= 1'b0;
            compute_q   <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            interval_q  <= interval_d;
            gen_count_q <= gen_count_d;
            changed_q   <= changed_d;
            empty_q     <= empty_d;
            load_edit_q <= load_edit_d;
            compute_q   <= compute_d;
            commit_q    <= commit_d;
        end
    end

    assign load_edit = load_edit_q;
    assign compute   = compute_q;
    assign commit    = commit_q;
    assign gen_count = gen_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_generation_controller.sv
// Bench for generation_controller: scenario tasks plus randomized traffic, each checked
// against a cycle-level reference model built from idle-time arithmetic.
module tb_generation_controller;

    localparam int BD = 4;
    localparam int EDIT = 0, LOAD = 1, IDLE = 2, COMP = 3, WAIT = 4, COMMIT = 5, HALT = 6;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        run_sw = 1'b0, pause_sw = 1'b0, step_req = 1'b0;
    logic [2:0]  speed = 3'd7;
    logic        next_valid = 1'b0, board_changed = 1'b1, board_empty = 1'b0;
    logic        load_edit, compute, commit, display_sel, halted;
    logic [15:0] gen_count;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int nv_cnt   = 0;
    int nv_delay = 2;
    bit nv_en    = 1'b1;
    bit gc_force = 1'b0;

    generation_controller #(.BASE_DIV(BD)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .run_sw       (run_sw),
        .pause_sw     (pause_sw),
        .step_req     (step_req),
        .speed        (speed),
        .next_valid   (next_valid),
        .board_changed(board_changed),
        .board_empty  (board_empty),
        .load_edit    (load_edit),
        .compute      (compute),
        .commit       (commit),
        .display_sel  (display_sel),
        .halted       (halted),
        .gen_count    (gen_count),
        .state        (state)
    );

    always #5 Clock = ~Clock;

    // Reference model: m_idle counts cycles spent in IDLE since the last generation tick.
    int          m_state = 0;
    int          m_idle  = 0;
    logic [15:0] m_gc    = 16'd0;
    logic        m_chg   = 1'b0, m_emp = 1'b0;

    function automatic bit tick_due(int idle_cycles, logic [2:0] spd);
        int n = idle_cycles + 1;
        return (n % BD == 0) && (n / BD >= 8 - int'(spd));
    endfunction

    always @(posedge Clock) begin
        if (!Reset) begin
            m_state <= EDIT;
            m_idle  <= 0;
            m_gc    <= 16'd0;
        end else begin
            case (m_state)
                EDIT: begin
                    m_idle <= 0;
                    if (run_sw) m_state <= LOAD;
                end
                LOAD: begin
                    m_idle  <= 0;
                    m_gc    <= 16'd0;
                    m_state <= IDLE;
                end
                IDLE: begin
                    m_idle <= tick_due(m_idle, speed) ? 0 : m_idle + 1;
                    if (!run_sw) m_state <= EDIT;
                    else if ((tick_due(m_idle, speed) && !pause_sw) || step_req) m_state <= COMP;
                end
                COMP: m_state <= WAIT;
                WAIT: begin
                    if (!run_sw) begin
                        m_state <= EDIT;
                    end else if (next_valid) begin
                        m_chg   <= board_changed;
                        m_emp   <= board_empty;
                        m_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    m_gc    <= (m_gc == 16'hFFFF) ? m_gc : m_gc + 16'd1;
                    m_state <= (m_emp || !m_chg) ? HALT : IDLE;
                end
                HALT: if (!run_sw) m_state <= EDIT;
                default: m_state <= EDIT;
            endcase
            if (gc_force) m_gc <= 16'hFFFF;
        end
    end

    function automatic logic [23:0] outs();
        return {load_edit, compute, commit, display_sel, halted, state, gen_count};
    endfunction

    function automatic logic [23:0] exp_out();
        logic disp = (m_state >= LOAD && m_state <= HALT);
        return {m_state == LOAD, m_state == COMP, m_state == COMMIT, disp, m_state == HALT,
                3'(m_state), m_gc};
    endfunction

    // Advance one cycle; the cell-array stand-in answers compute after nv_delay cycles.
    task automatic step_clk();
        @(posedge Clock);
        @(negedge Clock);
        cyc++;
        next_valid = 1'b0;
        if (nv_cnt > 0) begin
            nv_cnt--;
            if (nv_cnt == 0) next_valid = 1'b1;
        end
        if (compute && nv_en) nv_cnt = nv_delay;
    endtask

    task automatic restart();
        run_sw = 1'b0;
        step_req = 1'b0;
        nv_cnt = 0;
        repeat (3) step_clk();
        run_sw = 1'b1;
        step_clk();
        step_clk();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        run_sw = 1'b1;
        step_req = 1'b1;
        repeat (3) begin
            step_clk();
            n_checks++;
            if (outs() !== 24'h0) $display("FAIL reset_state: got %h want %h", outs(), 24'h0);
            else n_pass++;
        end
        step_req = 1'b0;
    endtask

    task automatic test_first_gen();
        int k = 0;
        speed = 3'd7; pause_sw = 1'b0; run_sw = 1'b0; nv_delay = 2; nv_en = 1'b1;
        board_changed = 1'b1; board_empty = 1'b0;
        Reset = 1'b1;
        step_clk();
        n_checks++;
        if (outs() !== exp_out() || {load_edit, compute, commit} !== 3'b000)
            $display("FAIL post_reset_quiet: got %h want %h", outs(), exp_out());
        else n_pass++;
        run_sw = 1'b1;
        step_clk();
        n_checks++;
        if (load_edit !== 1'b1 || state !== 3'd1 || outs() !== exp_out())
            $display("FAIL load_pulse: got %h want %h", outs(), exp_out());
        else n_pass++;
        step_clk();
        while (compute !== 1'b1 && k < 20) begin
            step_clk();
            k++;
            n_checks++;
            if (outs() !== exp_out()) $display("FAIL first_gen_seq: got %h want %h", outs(), exp_out());
            else n_pass++;
        end
        n_checks++;
        if (k !== 4) $display("FAIL first_compute_delay: got %0d want 4", k);
        else n_pass++;
        k = 0;
        while (commit !== 1'b1 && k < 10) begin
            step_clk();
            k++;
        end
        n_checks++;
        if (k !== 3) $display("FAIL commit_latency: got %0d want 3", k);
        else n_pass++;
        step_clk();
        n_checks++;
        if (state !== 3'd2 || gen_count !== 16'd1 || outs() !== exp_out())
            $display("FAIL first_gen_done: got %h want state 2 count 1", outs());
        else n_pass++;
    endtask

    task automatic test_free_run();
        int t[3];
        int commits = 0, idx = 0, t0 = 0, budget = 0;
        speed = 3'd0; pause_sw = 1'b0; nv_en = 1'b1;
        nv_delay = $urandom_range(1, 4);
        restart();
        t0 = cyc;
        while (commits < 3 && budget < 300) begin
            step_clk();
            budget++;
            if (compute === 1'b1 && idx < 3) begin t[idx] = cyc; idx++; end
            if (commit === 1'b1) commits++;
            n_checks++;
            if (outs() !== exp_out()) $display("FAIL free_run_seq: got %h want %h", outs(), exp_out());
            else n_pass++;
        end
        step_clk();
        n_checks++;
        if (idx !== 3 || gen_count !== 16'd3) $display("FAIL free_run_count: got %0d want 3", gen_count);
        else n_pass++;
        n_checks++;
        if (t[0] - t0 !== 8 * BD) $display("FAIL free_run_first: got %0d want %0d", t[0] - t0, 8 * BD);
        else n_pass++;
        n_checks++;
        if (t[1] - t[0] !== 8 * BD + 2 + nv_delay || t[2] - t[1] !== 8 * BD + 2 + nv_delay)
            $display("FAIL free_run_gap: got %0d/%0d want %0d", t[1] - t[0], t[2] - t[1],
                     8 * BD + 2 + nv_delay);
        else n_pass++;
    endtask

    task automatic test_pause_step();
        int commits = 0, k = 0;
        pause_sw = 1'b1; nv_en = 1'b1; nv_delay = 3; board_changed = 1'b1; board_empty = 1'b0;
        speed = 3'($urandom_range(4, 7));
        restart();
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        while (state !== 3'd4 && k < 10) begin step_clk(); k++; end
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        k = 0;
        while (state !== 3'd2 && k < 20) begin
            step_clk();
            k++;
            if (commit === 1'b1) commits++;
            n_checks++;
            if (outs() !== exp_out()) $display("FAIL pause_seq: got %h want %h", outs(), exp_out());
            else n_pass++;
        end
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        repeat (60) begin
            step_clk();
            if (commit === 1'b1) commits++;
            n_checks++;
            if (outs() !== exp_out()) $display("FAIL pause_hold: got %h want %h", outs(), exp_out());
            else n_pass++;
        end
        n_checks++;
        if (commits !== 2 || gen_count !== 16'd2)
            $display("FAIL pause_two_steps: got %0d commits count %0d want 2", commits, gen_count);
        else n_pass++;
    endtask

    task automatic test_halt();
        int k = 0;
        pause_sw = 1'b1; nv_en = 1'b1; nv_delay = 1; board_changed = 1'b0; board_empty = 1'b0;
        restart();
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        while (commit !== 1'b1 && k < 10) begin step_clk(); k++; end
        step_clk();
        n_checks++;
        if (state !== 3'd6 || halted !== 1'b1) $display("FAIL halt_enter: got %h want state 6", outs());
        else n_pass++;
        pause_sw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step_req = i[0];
            step_clk();
            n_checks++;
            if (outs() !== exp_out()) $display("FAIL halt_hold: got %h want %h", outs(), exp_out());
            else n_pass++;
        end
        step_req = 1'b0;
        n_checks++;
        if (state !== 3'd6 || gen_count !== 16'd1) $display("FAIL halt_ignore: got %h", outs());
        else n_pass++;
        run_sw = 1'b0;
        step_clk();
        n_checks++;
        if (state !== 3'd0 || display_sel !== 1'b0 || halted !== 1'b0)
            $display("FAIL halt_exit: got %h want state 0 disp 0", outs());
        else n_pass++;
    endtask

    task automatic test_abort();
        int k = 0, commits = 0;
        pause_sw = 1'b1; nv_en = 1'b1; nv_delay = 1; board_changed = 1'b1; board_empty = 1'b0;
        restart();
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        while (state !== 3'd2 && k < 10) begin step_clk(); k++; end
        nv_en = 1'b0;
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        repeat (4) step_clk();
        run_sw = 1'b0;
        step_clk();
        n_checks++;
        if (state !== 3'd0 || commit !== 1'b0 || gen_count !== 16'd1)
            $display("FAIL abort_wait: got %h want state 0 count 1", outs());
        else n_pass++;
        repeat (5) begin
            step_clk();
            if (commit === 1'b1) commits++;
        end
        n_checks++;
        if (commits !== 0 || gen_count !== 16'd1) $display("FAIL abort_no_commit: got %0d", commits);
        else n_pass++;
    endtask

    task automatic test_reset_and_saturate();
        int k;
        pause_sw = 1'b1; nv_en = 1'b1; nv_delay = 1; board_changed = 1'b1; board_empty = 1'b0;
        restart();
        repeat (5) begin
            step_req = 1'b1; step_clk(); step_req = 1'b0;
            k = 0;
            while (state !== 3'd2 && k < 10) begin step_clk(); k++; end
        end
        n_checks++;
        if (gen_count !== 16'd5) $display("FAIL five_gens: got %0d want 5", gen_count);
        else n_pass++;
        nv_en = 1'b0;
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        step_clk();
        Reset = 1'b0;
        step_clk();
        n_checks++;
        if (outs() !== 24'h0) $display("FAIL reset_in_wait: got %h want %h", outs(), 24'h0);
        else n_pass++;
        Reset = 1'b1;
        restart();
        gc_force = 1'b1;
        force dut.gen_count_q = 16'hFFFF;
        step_clk();
        release dut.gen_count_q;
        gc_force = 1'b0;
        nv_en = 1'b1;
        step_req = 1'b1; step_clk(); step_req = 1'b0;
        k = 0;
        while (state !== 3'd2 && k < 10) begin
            step_clk();
            k++;
            n_checks++;
            if (outs() !== exp_out()) $display("FAIL sat_seq: got %h want %h", outs(), exp_out());
            else n_pass++;
        end
        n_checks++;
        if (gen_count !== 16'hFFFF) $display("FAIL gen_count_sat: got %h want ffff", gen_count);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            Reset         = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 79) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 49) == 0) pause_sw = ~pause_sw;
            if ($urandom_range(0, 99) == 0) speed = 3'($urandom_range(5, 7));
            step_req      = ($urandom_range(0, 15) == 0);
            board_changed = ($urandom_range(0, 3) != 0);
            board_empty   = ($urandom_range(0, 7) == 0);
            nv_delay      = $urandom_range(1, 3);
            nv_en         = 1'b1;
            step_clk();
            n_checks++;
            if (outs() !== exp_out()) $display("FAIL random_cyc%0d: got %h want %h", i, outs(), exp_out());
            else n_pass++;
        end
    endtask

    initial begin
        @(negedge Clock);
        test_reset();
        test_first_gen();
        test_free_run();
        test_pause_step();
        test_halt();
        test_abort();
        test_reset_and_saturate();
        run_sw = 1'b1;
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
